// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read- and write-side controllers.
// Holds the default depth exponent and the Gray/binary conversion helpers.
// Helpers operate on 32-bit values; callers zero-extend and truncate with casts.
package async_fifo_pkg;

    localparam int unsigned FIFO_DEPTH_BIT_DEFAULT = 4;
    localparam int unsigned CONV_W                 = 32;

    // Binary to reflected Gray code.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary; zero upper bits keep narrower values exact.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < int'(CONV_W); i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of parameterized width.
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent (combinational)
module gray_to_bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer and status controller of an asynchronous FIFO.
// Keeps the binary read pointer, publishes its Gray form to the write domain,
// and derives empty / almost_empty / fill level from the synchronized Gray
// write pointer. Every status output reflects the pointer after this cycle's read.
// Optional feature: define ASYNC_FIFO_RD_UNDERFLOW_EN for a sticky underflow flag
// (read_en while empty); otherwise underflow is constant 0.
// Ports:
//   r_clk                 in   1      read-domain clock
//   r_rst_n               in   1      synchronous active-low reset
//   read_en               in   1      consumer read request
//   write_addr_gray_sync  in   PW     synchronized Gray write pointer
//   read_addr_gray        out  PW     registered Gray read pointer
//   read_addr             out  DW     memory read address
//   empty                 out  1      registered empty flag
//   almost_empty          out  1      registered low-level flag
//   rd_level              out  PW     registered fill level
//   underflow             out  1      sticky underflow flag
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_BIT  = FIFO_DEPTH_BIT_DEFAULT,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                      r_clk,
    input  logic                      r_rst_n,
    input  logic                      read_en,
    input  logic [FIFO_DEPTH_BIT:0]   write_addr_gray_sync,
    output logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
    output logic [FIFO_DEPTH_BIT-1:0] read_addr,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_BIT:0]   rd_level,
    output logic                      underflow
);

    localparam int unsigned PW = FIFO_DEPTH_BIT + 1;

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] level_next;
    logic          read_fire;

    gray_to_bin #(
        .WIDTH (PW)
    ) u_wr_g2b (
        .gray (write_addr_gray_sync),
        .bin  (wr_bin)
    );

    // Next pointer and the status it implies; modulo arithmetic handles wrap.
    always_comb begin
        read_fire    = read_en & ~empty;
        rd_bin_next  = rd_bin + PW'(read_fire);
        rd_gray_next = PW'(bin2gray(CONV_W'(rd_bin_next)));
        level_next   = wr_bin - rd_bin_next;
    end

    // Pointer and status registers.
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            rd_bin         <= '0;
            read_addr_gray <= '0;
            empty          <= 1'b1;
            almost_empty   <= 1'b1;
            rd_level       <= '0;
        end else begin
            rd_bin         <= rd_bin_next;
            read_addr_gray <= rd_gray_next;
            empty          <= (rd_gray_next == write_addr_gray_sync);
            almost_empty   <= (CONV_W'(level_next) <= CONV_W'(ALMOST_EMPTY_TH));
            rd_level       <= level_next;
        end
    end

    assign read_addr = rd_bin[FIFO_DEPTH_BIT-1:0];

`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
    // Sticky: set by any read attempt while empty, cleared only by reset.
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            underflow <= 1'b0;
        end else if (read_en && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl (FIFO_DEPTH_BIT=4): directed stimulus, a
// pointer/level model compared every cycle, plus literal spot checks.
module tb_async_fifo_rd_ctrl;

    localparam int DW = 4;
    localparam int PW = 5;
    localparam int MOD = 32;

    logic          r_clk = 1'b0;
    logic          r_rst_n = 1'b0;
    logic          read_en = 1'b0;
    logic [PW-1:0] write_addr_gray_sync = '0;
    logic [PW-1:0] read_addr_gray;
    logic [DW-1:0] read_addr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    async_fifo_rd_ctrl #(
        .FIFO_DEPTH_BIT  (4),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .r_clk                (r_clk),
        .r_rst_n              (r_rst_n),
        .read_en              (read_en),
        .write_addr_gray_sync (write_addr_gray_sync),
        .read_addr_gray       (read_addr_gray),
        .read_addr            (read_addr),
        .empty                (empty),
        .almost_empty         (almost_empty),
        .rd_level             (rd_level),
        .underflow            (underflow)
    );

    always #5 r_clk = ~r_clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: read count modulo 32, write count modulo 32, sticky error.
    int m_rp = 0;
    int m_wp = 0;
    bit m_empty = 1'b1;
    bit m_uf = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge r_clk) begin
        if (!r_rst_n) begin
            m_rp    = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (read_en && m_empty) m_uf = 1'b1;
            if (read_en && !m_empty) m_rp = (m_rp + 1) % MOD;
            m_empty = (m_wp == m_rp);
        end
    end

    int m_lvl;
    always @(negedge r_clk) begin
        if (m_valid) begin
            m_lvl = r_rst_n_seen_lvl();
            chk("read_addr",      int'(read_addr),      m_rp % 16);
            chk("read_addr_gray", int'(read_addr_gray), to_gray(m_rp));
            chk("empty",          int'(empty),          int'(m_empty));
            chk("rd_level",       int'(rd_level),       m_lvl);
            chk("almost_empty",   int'(almost_empty),   int'(m_lvl <= 2));
`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
            chk("underflow",      int'(underflow),      int'(m_uf));
`else
            chk("underflow",      int'(underflow),      0);
`endif
        end
    end

    // Level as seen after the last edge: zero straight after reset, else distance.
    int lvl_snap = 0;
    always @(posedge r_clk) begin
        #0;
        lvl_snap = r_rst_n ? ((m_wp - m_rp + MOD) % MOD) : 0;
    end
    function automatic int r_rst_n_seen_lvl();
        return lvl_snap;
    endfunction

    // Apply one cycle of inputs (wp as binary write count), then step past the edge.
    task automatic cyc(input bit rst_n, input bit ren, input int wp);
        r_rst_n = rst_n;
        read_en = ren;
        m_wp    = wp % MOD;
        write_addr_gray_sync = PW'(to_gray(wp % MOD));
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset with write pointer at zero.
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("rst_empty",   int'(empty), 1);
        chk("rst_ae",      int'(almost_empty), 1);
        chk("rst_level",   int'(rd_level), 0);
        chk("rst_gray",    int'(read_addr_gray), 0);

        // Three entries written, then drained.
        cyc(1, 0, 3);
        chk("w3_empty", int'(empty), 0);
        chk("w3_level", int'(rd_level), 3);
        chk("w3_ae",    int'(almost_empty), 0);
        chk("rd0_addr", int'(read_addr), 0);
        cyc(1, 1, 3);
        chk("rd1_addr", int'(read_addr), 1);
        cyc(1, 1, 3);
        chk("rd2_addr", int'(read_addr), 2);
        cyc(1, 1, 3);
        chk("drain_empty", int'(empty), 1);
        chk("drain_level", int'(rd_level), 0);

        // Stream one ahead of the reader up to pointer 31, then wrap to 0.
        for (int i = 1; i <= 28; i++) cyc(1, 1, 3 + i);
        cyc(1, 1, 31);
        chk("p31_gray",  int'(read_addr_gray), 5'b10000);
        chk("p31_empty", int'(empty), 1);
        cyc(1, 1, 32);
        chk("wrap_level", int'(rd_level), 1);
        cyc(1, 1, 32);
        chk("wrap_gray",  int'(read_addr_gray), 0);
        chk("wrap_addr",  int'(read_addr), 0);
        chk("wrap_empty", int'(empty), 1);

        // Full FIFO, then simultaneous write and read.
        cyc(0, 0, 0);
        cyc(1, 0, 16);
        chk("full_level", int'(rd_level), 16);
        chk("full_empty", int'(empty), 0);
        cyc(1, 1, 17);
        chk("full_rw_level", int'(rd_level), 16);
        chk("full_rw_addr",  int'(read_addr), 1);

        // Reads while empty are ignored.
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("uf_gray", int'(read_addr_gray), 0);
`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
        chk("uf_set", int'(underflow), 1);
`else
        chk("uf_off", int'(underflow), 0);
`endif
        cyc(1, 0, 0);
`ifdef ASYNC_FIFO_RD_UNDERFLOW_EN
        chk("uf_hold", int'(underflow), 1);
`else
        chk("uf_hold", int'(underflow), 0);
`endif

        // Reset mid-operation with rd_bin=7, level 5.
        cyc(0, 0, 0);
        cyc(1, 0, 12);
        for (int i = 0; i < 7; i++) cyc(1, 1, 12);
        chk("mid_addr",  int'(read_addr), 7);
        chk("mid_level", int'(rd_level), 5);
        cyc(0, 1, 12);
        chk("mrst_addr",  int'(read_addr), 0);
        chk("mrst_gray",  int'(read_addr_gray), 0);
        chk("mrst_empty", int'(empty), 1);
        chk("mrst_ae",    int'(almost_empty), 1);
        chk("mrst_level", int'(rd_level), 0);
        chk("mrst_uf",    int'(underflow), 0);
        cyc(1, 0, 12);
        chk("resume_level", int'(rd_level), 12);

        @(negedge r_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_BIT, default 4: log2 of FIFO depth; pointers are FIFO_DEPTH_BIT+1 bits.
REQ-002 SHALL have parameter ALMOST_EMPTY_TH, default 2: almost_empty asserts at fill level <= this value.
REQ-003 r_clk  input  1  read-domain clock; the only clock; all logic on its rising edge.
REQ-004 r_rst_n  input  1  reset, synchronous to r_clk, active-low.
REQ-005 read_en  input  1  read request from consumer.
REQ-006 write_addr_gray_sync  input  FIFO_DEPTH_BIT+1  write pointer, Gray code, already synchronized into r_clk.
REQ-007 read_addr_gray  output  FIFO_DEPTH_BIT+1  registered Gray read pointer, sent to write domain.
REQ-008 read_addr  output  FIFO_DEPTH_BIT  memory read address.
REQ-009 empty  output  1  registered empty flag.
REQ-010 almost_empty  output  1  registered low-level flag.
REQ-011 rd_level  output  FIFO_DEPTH_BIT+1  registered fill level seen by reader.
REQ-012 underflow  output  1  sticky underflow error flag.

Function
REQ-013 read_fire = read_en & ~empty; only read_fire advances the pointer.
REQ-014 Binary read pointer rd_bin (FIFO_DEPTH_BIT+1 bits) SHALL increment by 1 on read_fire, wrapping modulo 2^(FIFO_DEPTH_BIT+1).
REQ-015 read_addr SHALL equal rd_bin[FIFO_DEPTH_BIT-1:0] (current, pre-increment pointer).
REQ-016 read_addr_gray SHALL be registered bin2gray(rd_bin_next), so it changes one bit at most per cycle, same cycle as rd_bin.
REQ-017 empty SHALL be registered as (bin2gray(rd_bin_next) == write_addr_gray_sync); one-cycle latency from input change.
REQ-018 rd_level SHALL be registered (gray2bin(write_addr_gray_sync) - rd_bin_next) modulo 2^(FIFO_DEPTH_BIT+1); full FIFO reads 2^FIFO_DEPTH_BIT.
REQ-019 almost_empty SHALL be registered (level_next <= ALMOST_EMPTY_TH); asserts whenever empty asserts.
REQ-020 read_en while empty SHALL be ignored: pointer, read_addr_gray unchanged.
REQ-021 Write pointer advancing in the same cycle as read_fire SHALL yield net level change of zero.
REQ-022 Pointer wrap from all-ones to zero SHALL not disturb empty/level correctness.

Reset
REQ-023 On r_clk edge with r_rst_n=0: rd_bin=0, read_addr_gray=0, read_addr=0, empty=1, almost_empty=1, rd_level=0, underflow=0.
REQ-024 Reset mid-operation SHALL override read_en in that cycle; normal operation resumes the cycle after r_rst_n=1.

Configuration
REQ-025 Macro ASYNC_FIFO_RD_UNDERFLOW_EN defined: underflow sets on read_en & empty, holds until reset.
REQ-026 Macro undefined: underflow tied to 0, no register inferred; port remains.

Structure
REQ-027 Package async_fifo_pkg SHALL hold default FIFO_DEPTH_BIT constant and bin2gray/gray2bin functions, shared with write-side controller.
REQ-028 One sub-module gray_to_bin (combinational, parameterized width) SHALL perform the write-pointer conversion for rd_level.

Verification (FIFO_DEPTH_BIT=4)
REQ-029 Reset, write_addr_gray_sync=0 -> empty=1, almost_empty=1, rd_level=0, read_addr_gray=0.
REQ-030 write_addr_gray_sync=bin2gray(3), no reads -> next cycle empty=0, rd_level=3, almost_empty=0; three read_en cycles -> read_addr 0,1,2, then empty=1, rd_level=0.
REQ-031 Pointers at 31 (gray 10000), write advances to 0 (wrap), one read -> rd_bin=0, read_addr_gray=00000, empty=1.
REQ-032 Full: write pointer gray of 16, rd_bin=0 -> rd_level=16; simultaneous write step and read -> rd_level stays 16.
REQ-033 read_en held while empty -> pointer unchanged; with ASYNC_FIFO_RD_UNDERFLOW_EN underflow=1 next cycle and stays 1 until r_rst_n=0; without macro underflow=0.
REQ-034 r_rst_n=0 asserted with rd_bin=7, level 5 -> next cycle all outputs at reset values regardless of read_en.
